// File: rtl/emu_alu_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
// Holds the FSM state type, the chunk-count helper and saturation limits.
package emu_alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int nchunk(int w, int c);
        return w / c;
    endfunction

    // Largest signed value of a w-bit word: 0111..1
    function automatic logic [63:0] max_s(int w);
        return ~64'd0 >> (65 - w);
    endfunction

    // Smallest signed value of a w-bit word: 1000..0
    function automatic logic [63:0] min_s(int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder slice.
// Ports: a, b, ci in; s (sum), co (carry out), c_msb_in (carry into top bit) out.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle chunk-serial adder/subtractor with C/V/Z/N flags and
// valid/ready handshakes. Optional clamp on overflow: EMU_ADD_SAT_EN.
// Ports: CLK, RST (sync, active high); in_valid/in_ready, A, B, Cin, SUB;
//        out_valid/out_ready, S, Cout, V, Z, N.
module seq_add_sub
    import emu_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

`ifdef EMU_ADD_SAT_EN
    localparam logic [63:0] MAX64 = max_s(WIDTH);
    localparam logic [63:0] MIN64 = min_s(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN = MIN64[WIDTH-1:0];
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
    logic             co_ch, cmsb_ch;
    logic [WIDTH-1:0] s_w;

    assign a_ch = a_q[idx_q*CHUNK +: CHUNK];
    assign b_ch = b_q[idx_q*CHUNK +: CHUNK];

    add_chunk #(.CHUNK(CHUNK)) u_add (
        .a        (a_ch),
        .b        (b_ch),
        .ci       (c_q),
        .s        (sum_ch),
        .co       (co_ch),
        .c_msb_in (cmsb_ch)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        // Result as it will look once this cycle's chunk is written
        s_w = s_q;
        s_w[idx_q*CHUNK +: CHUNK] = sum_ch;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{SUB}};
                    c_d     = Cin;
                    s_d     = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d = s_w;
                c_d = co_ch;
                if (idx_q == LAST) begin
                    cout_d  = co_ch;
                    v_d     = cmsb_ch ^ co_ch;
                    n_d     = s_w[WIDTH-1];
                    z_d     = (s_w == '0);
`ifdef EMU_ADD_SAT_EN
                    // Flags other than Z keep the unsaturated result
                    if (cmsb_ch ^ co_ch) begin
                        s_d = a_q[WIDTH-1] ? SMIN : SMAX;
                        z_d = 1'b0;
                    end
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign Z         = z_q;
    assign N         = n_q;

endmodule
